// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg
//   Shared definitions for the parallel-in/serial-out symbol streamer:
//   FSM state encoding, symbol-counter width helper and parameter
//   legality check.
package piso_stream_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // A word must split into at least two symbols.
    localparam int MIN_SYMS = 2;

    // Width needed to hold the values 0..n.
    function automatic int piso_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bit piso_params_ok(input int word_w, input int sym_w);
        if (sym_w <= 0) return 1'b0;
        return ((word_w % sym_w) == 0) && ((word_w / sym_w) >= MIN_SYMS);
    endfunction

endpackage

// File: rtl/piso_word_buf.sv
// piso_word_buf
//   One-word holding register with a valid flag. It lets the streamer
//   fetch the next FIFO word while the current word is still shifting.
//   Ports:
//     clk, rst_n    clock, synchronous active-low reset
//     i_clear       drop the held word (flush)
//     i_load        capture i_data and mark valid
//     i_data        word to hold
//     i_take        held word consumed this cycle
//     o_valid       a word is held
//     o_data        held word
module piso_word_buf #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_take,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data
);

    logic              r_valid;
    logic [WORD_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/piso_stream.sv
// piso_stream
//   Reads WORD_W-bit words from a standard-latency FIFO (data valid the
//   cycle after the read strobe) and emits WORD_W/SYM_W symbols per word
//   on a valid/ready stream, marking the last symbol of each word.
//   Optional feature macro: PISO_STREAM_PREFETCH_EN adds a one-word
//   prefetch buffer so consecutive words stream with no bubble.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     fifo_data_i    FIFO read data
//     fifo_empty_i   FIFO empty flag
//     fifo_rd_en_o   FIFO read strobe (combinational)
//     flush_i        discard all held and in-flight data
//     sym_data_o     current symbol
//     sym_valid_o    symbol valid
//     sym_last_o     last symbol of the word
//     sym_ready_i    downstream accept
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_EMPTY | no word held
//   ST_LOAD  | read issued last cycle, FIFO data arrives now
//   ST_SHIFT | word held, r_count symbols remain (1..N)
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int SYM_W     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic              flush_i,
    output logic [SYM_W-1:0]  sym_data_o,
    output logic              sym_valid_o,
    output logic              sym_last_o,
    input  logic              sym_ready_i
);

    localparam int N  = WORD_W / SYM_W;
    localparam int CW = piso_cnt_w(N);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (!piso_params_ok(WORD_W, SYM_W)) begin : g_bad_params
        $error("piso_stream: WORD_W must be a multiple of SYM_W with at least 2 symbols");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_nxt;

    logic w_accept;
    logic w_last_acc;
    logic w_slot_free;
    logic w_rd_outst;
    logic w_rd_en;

    assign w_accept   = (r_state == ST_SHIFT) && sym_ready_i;
    assign w_last_acc = w_accept && (r_count == CNT_ONE);

`ifdef PISO_STREAM_PREFETCH_EN
    logic              r_buf_pend;
    logic              w_buf_valid;
    logic [WORD_W-1:0] w_buf_data;
    logic              w_take_buf;

    // A read may target the buffer while shifting; the slot is also free
    // when the held word is moving into the shifter on this edge.
    assign w_rd_outst  = (r_state == ST_LOAD) || r_buf_pend;
    assign w_slot_free = (!w_buf_valid && !r_buf_pend) || (w_last_acc && w_buf_valid);

    // Reads whose data is not headed for the shifter (via ST_LOAD) land
    // in the buffer one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_pend <= 1'b0;
        end else begin
            r_buf_pend <= w_rd_en && (w_state_nxt != ST_LOAD);
        end
    end

    piso_word_buf #(
        .WORD_W (WORD_W)
    ) u_word_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush_i),
        .i_load  (r_buf_pend && !flush_i),
        .i_data  (fifo_data_i),
        .i_take  (w_take_buf),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data)
    );
`else
    assign w_rd_outst  = (r_state == ST_LOAD);
    assign w_slot_free = (r_state == ST_EMPTY) || w_last_acc;
`endif

    // Gated by rst_n so no read is issued while reset is asserted.
    assign w_rd_en = rst_n && !fifo_empty_i && !flush_i && !w_rd_outst && w_slot_free;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_shift_nxt = r_shift;
`ifdef PISO_STREAM_PREFETCH_EN
        w_take_buf  = 1'b0;
`endif
        unique case (r_state)
            ST_EMPTY: begin
                if (w_rd_en) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_state_nxt = ST_SHIFT;
                w_shift_nxt = fifo_data_i;
                w_count_nxt = CNT_N;
            end
            ST_SHIFT: begin
                if (w_accept) begin
                    if (r_count == CNT_ONE) begin
`ifdef PISO_STREAM_PREFETCH_EN
                        if (w_buf_valid) begin
                            w_take_buf  = 1'b1;
                            w_shift_nxt = w_buf_data;
                            w_count_nxt = CNT_N;
                        end else
`endif
                        if (w_rd_en) begin
                            w_state_nxt = ST_LOAD;
                            w_count_nxt = '0;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                            w_count_nxt = '0;
                        end
                    end else begin
                        w_shift_nxt = MSB_FIRST ? (r_shift << SYM_W) : (r_shift >> SYM_W);
                        w_count_nxt = r_count - CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_count_nxt = '0;
            end
        endcase
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_count_nxt = '0;
`ifdef PISO_STREAM_PREFETCH_EN
            w_take_buf  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_count <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    assign fifo_rd_en_o = w_rd_en;
    assign sym_valid_o  = (r_state == ST_SHIFT);
    assign sym_last_o   = (r_state == ST_SHIFT) && (r_count == CNT_ONE);
    assign sym_data_o   = MSB_FIRST ? r_shift[WORD_W-1 -: SYM_W] : r_shift[SYM_W-1:0];

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

`ifdef PISO_STREAM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    typedef struct {
        bit          push;
        logic [15:0] word;
        bit          ready;
        bit          flush;
        bit          e_rd;
        bit          e_valid;
        logic [1:0]  e_dm;
        logic [1:0]  e_dl;
        bit          e_last;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic        flush;
    logic        sym_ready;
    logic        rd_m, rd_l;
    logic [1:0]  d_m, d_l;
    logic        v_m, v_l, l_m, l_l;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] fq[$];
    bit          rd_prev = 1'b0;
    bit          rst_drv = 1'b0;
    vec_t        tbl[$];
    logic [1:0]  sm[8];
    logic [1:0]  sl[8];

    piso_stream #(.WORD_W(16), .SYM_W(2), .MSB_FIRST(1'b1)) dut_m (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_i  (fifo_data),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (rd_m),
        .flush_i      (flush),
        .sym_data_o   (d_m),
        .sym_valid_o  (v_m),
        .sym_last_o   (l_m),
        .sym_ready_i  (sym_ready)
    );

    piso_stream #(.WORD_W(16), .SYM_W(2), .MSB_FIRST(1'b0)) dut_l (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_i  (fifo_data),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (rd_l),
        .flush_i      (flush),
        .sym_data_o   (d_l),
        .sym_valid_o  (v_l),
        .sym_last_o   (l_l),
        .sym_ready_i  (sym_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: FIFO model answers last cycle's read, inputs are
    // driven at the falling edge and outputs settle before returning.
    task automatic cyc(input bit push, input logic [15:0] w, input bit rdy, input bit fl);
        @(negedge clk);
        rst_n = rst_drv;
        if (rd_prev) begin
            if (fq.size() > 0) fifo_data = fq.pop_front();
            else chk("fifo_underflow", 32'd1, 32'd0);
        end
        if (push) fq.push_back(w);
        fifo_empty = (fq.size() == 0);
        sym_ready  = rdy;
        flush      = fl;
        #1;
        rd_prev = rd_m;
    endtask

    function automatic vec_t mk(bit push, logic [15:0] w, bit rdy, bit erd, bit ev,
                                logic [1:0] edm, logic [1:0] edl, bit el);
        vec_t v;
        v.push = push; v.word = w; v.ready = rdy; v.flush = 1'b0;
        v.e_rd = erd; v.e_valid = ev; v.e_dm = edm; v.e_dl = edl; v.e_last = el;
        return v;
    endfunction

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            cyc(tbl[i].push, tbl[i].word, tbl[i].ready, tbl[i].flush);
            chk($sformatf("%s[%0d] rd_m", tag, i - lo), 32'(rd_m), 32'(tbl[i].e_rd));
            chk($sformatf("%s[%0d] rd_l", tag, i - lo), 32'(rd_l), 32'(tbl[i].e_rd));
            chk($sformatf("%s[%0d] valid_m", tag, i - lo), 32'(v_m), 32'(tbl[i].e_valid));
            chk($sformatf("%s[%0d] valid_l", tag, i - lo), 32'(v_l), 32'(tbl[i].e_valid));
            chk($sformatf("%s[%0d] last_m", tag, i - lo), 32'(l_m), 32'(tbl[i].e_last));
            chk($sformatf("%s[%0d] last_l", tag, i - lo), 32'(l_l), 32'(tbl[i].e_last));
            if (tbl[i].e_valid) begin
                chk($sformatf("%s[%0d] data_m", tag, i - lo), 32'(d_m), 32'(tbl[i].e_dm));
                chk($sformatf("%s[%0d] data_l", tag, i - lo), 32'(d_l), 32'(tbl[i].e_dl));
            end
        end
    endtask

    initial begin
        int na, nb, nsym, first_v, last_v;
        bit v_at10;
        logic [1:0] exp_sym;

        rst_n = 1'b0; fifo_data = '0; fifo_empty = 1'b1; flush = 1'b0; sym_ready = 1'b1;

        // 0xB41F split MSB-first and LSB-first.
        sm = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3};
        sl = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};

        // Table A: first word after reset release, ready held high.
        tbl.push_back(mk(0, 16'h0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 16'h0, 1, 0, 1, sm[k], sl[k], k == 7));
        tbl.push_back(mk(0, 16'h0, 1, 0, 0, 0, 0, 0));
        na = tbl.size();
        // Table B: ready low for 5 cycles while the third symbol is shown.
        tbl.push_back(mk(1, 16'hB41F, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0, 1, 0, 1, sm[0], sl[0], 0));
        tbl.push_back(mk(0, 16'h0, 1, 0, 1, sm[1], sl[1], 0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 16'h0, 0, 0, 1, sm[2], sl[2], 0));
        for (int k = 2; k < 8; k++) tbl.push_back(mk(0, 16'h0, 1, 0, 1, sm[k], sl[k], k == 7));
        tbl.push_back(mk(0, 16'h0, 1, 0, 0, 0, 0, 0));
        nb = tbl.size();

        // Reset held with a word waiting in the FIFO.
        for (int i = 0; i < 3; i++) begin
            cyc(i == 0, 16'hB41F, 1, 0);
            chk($sformatf("reset[%0d] rd_m", i), 32'(rd_m), 32'd0);
            chk($sformatf("reset[%0d] rd_l", i), 32'(rd_l), 32'd0);
            chk($sformatf("reset[%0d] valid", i), 32'({v_m, v_l}), 32'd0);
            chk($sformatf("reset[%0d] last", i), 32'({l_m, l_l}), 32'd0);
            chk($sformatf("reset[%0d] data", i), 32'({d_m, d_l}), 32'd0);
        end
        rst_drv = 1'b1;

        run_rows(0, na, "single");
        run_rows(na, nb, "backpr");

        // Back-to-back words 0x0000 then 0xFFFF.
        fq.push_back(16'h0000);
        fq.push_back(16'hFFFF);
        nsym = 0; first_v = -1; last_v = -1; v_at10 = 1'b0;
        for (int c = 0; c < 22; c++) begin
            cyc(0, 16'h0, 1, 0);
            if (c == 0) chk("b2b rd_c0", 32'(rd_m), 32'd1);
            if (c == 10) v_at10 = v_m;
            if (v_m) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                chk($sformatf("b2b sym%0d data", nsym), 32'(d_m), (nsym < 8) ? 32'd0 : 32'd3);
                chk($sformatf("b2b sym%0d last", nsym), 32'(l_m), 32'(nsym == 7 || nsym == 15));
                nsym++;
            end
        end
        chk("b2b symbol_count", 32'(nsym), 32'd16);
        chk("b2b first_valid", 32'(first_v), 32'd2);
        chk("b2b valid_c10", 32'(v_at10), 32'(PF));
        chk("b2b last_valid", 32'(last_v), PF ? 32'd17 : 32'd18);

        // Flush during the fourth symbol of 0xB41F; words 0x5555, 0xAAAA queued.
        exp_sym = PF ? 2'd2 : 2'd1;
        fq.push_back(16'hB41F);
        for (int c = 0; c < 17; c++) begin
            cyc(c == 4, 16'h5555, 1, c == 5);
            if (c == 4) fq.push_back(16'hAAAA);
            if (c == 5) begin
                chk("flush c5 valid", 32'(v_m), 32'd1);
                chk("flush c5 data", 32'(d_m), 32'(sm[3]));
                chk("flush c5 rd", 32'(rd_m), 32'd0);
            end
            if (c == 6) begin
                chk("flush c6 valid", 32'(v_m), 32'd0);
                chk("flush c6 rd", 32'(rd_m), 32'd1);
            end
            if (c == 7) chk("flush c7 valid", 32'(v_m), 32'd0);
            if (c >= 8 && c <= 15) begin
                chk($sformatf("flush c%0d valid", c), 32'(v_m), 32'd1);
                chk($sformatf("flush c%0d data", c), 32'(d_m), 32'(exp_sym));
                chk($sformatf("flush c%0d last", c), 32'(l_m), 32'(c == 15));
            end
            if (c == 16) chk("flush c16 valid", 32'(v_m), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
